neural_argmax_seg: RTL and testbench
====================================

// Module: neural_argmax_seg
// PURPOSE
//  Streaming classifier back-end: accepts NUM_CLASSES unsigned neural-network scores serially over a
//  valid/ready interface and tracks the best and second-best score and the winning index.
//  Drives a registered seven-segment pattern, the class index and a confidence flag once per frame.
//  Sits between the neural accumulator output stage and the board display driver.
// PARAMETERS
//  NUM_CLASSES  10  scores per frame (>=1)
//  DATA_W       16  score width, unsigned
//  IDX_W        derived localparam = max(1,$clog2(NUM_CLASSES)); width of class_idx and beat counter
// PORTS
//  clk          in   1       system clock, rising edge
//  n_rst        in   1       asynchronous active-low reset
//  score_in     in   DATA_W  score for class at current beat position
//  score_valid  in   1       score_in valid
//  score_ready  out  1       block can accept a score this cycle
//  frame_clr    in   1       synchronous abort of partial frame
//  conf_margin  in   DATA_W  minimum (best - second) for a confident result
//  seven_seg    out  8       segment pattern hgfedcba, h = dp, active-high
//  class_idx    out  IDX_W   winning class of last completed frame
//  confident    out  1       last result met conf_margin
//  result_valid out  1       one-cycle pulse: new result on outputs
// BEHAVIOUR
//  - Reset: state ACCUM, beat=0, best=0, second=0, best_idx=0; seven_seg=8'h00, class_idx=0,
//    confident=0, result_valid=0.
//  - score_ready = (state==ACCUM) & ~frame_clr (combinational). Beat accepted on edge where valid&ready.
//  - States: ACCUM -> DECIDE when beat NUM_CLASSES-1 is accepted; DECIDE -> ACCUM unconditionally.
//  - Beat 0: best=score, best_idx=0, second=0. Beat i>0: if score>best {second=best; best=score;
//    best_idx=i} else if score>second {second=score}. Strict '>' : ties keep the lower index.
//  - Cycles with score_valid=0 mid-frame do not advance beat; no timeout.
//  - DECIDE (one cycle, ready=0): diff=best-second (never underflows); conf = diff>=conf_margin,
//    conf_margin sampled this cycle. On the edge leaving DECIDE: class_idx=best_idx, confident=conf,
//    seven_seg updated, result_valid=1 for exactly the following cycle; beat=0.
//  - Latency: last beat accepted on edge k -> outputs/result_valid change on edge k+1. Throughput:
//    NUM_CLASSES+1 cycles/frame minimum (one bubble).
//  - Digit map (confident): 0 3F,1 06,2 5B,3 4F,4 66,5 6D,6 7D,7 07,8 7F,9 6F,A 77,b 7C,C 39,d 5E,
//    E 79,F 71; best_idx>=16 -> 8'h40 (dash).
//  - Not confident: seven_seg=8'h00 (see CONFIGURATION); class_idx still reports best_idx.
//  - frame_clr: in ACCUM, beat/best/second/best_idx cleared next edge; beat presented that cycle
//    discarded (ready=0). In DECIDE, ignored (result completes). Outputs hold last result.
//  - Outputs hold between results; only reset or a new frame changes them.
//  - n_rst low mid-frame: all state and outputs return to reset values immediately.
// CONFIGURATION
//  NEURAL_SEG_DP_EN defined: non-confident result shows digit pattern of best_idx with bit7 (dp)=1,
//    e.g. idx 0 -> 8'hBF; confident results keep dp=0.
//  NEURAL_SEG_DP_EN undefined: non-confident result blanks seven_seg to 8'h00.
// TESTING (NUM_CLASSES=10, DATA_W=16, conf_margin=16'd64 unless stated)
//  1 Reset asserted then released -> seven_seg=00, class_idx=0, confident=0, result_valid=0,
//    score_ready=1.
//  2 Frame 07F2,01BB,00BF,01D7,0065,0208,001A,0037,001F,0017 -> seven_seg=3F, class_idx=0,
//    confident=1, result_valid one pulse, edge after DECIDE.
//  3 Frame 00C5,002F,0104,0018,0F26,0012,0026,005C,002A,00E9 -> seven_seg=66, class_idx=4,
//    confident=1.
//  4 Frame 01F2,01BB,00BF,01D7,0065,0208,001A,0037,001F,0017 (best 0208 idx5, second 01F2, diff 22)
//    -> seven_seg=00 (BF-style 8'hED with NEURAL_SEG_DP_EN), class_idx=5, confident=0.
//  5 All ten scores 0100, conf_margin=0 -> class_idx=0 (tie to lowest), diff 0 >= 0, confident=1,
//    seven_seg=3F.
//  6 Five beats, frame_clr, then frame of test 3 with score_valid gaps -> exactly one result_valid,
//    seven_seg=66; score_ready=0 during DECIDE and while frame_clr=1.

Source files
------------

// File: rtl/neural_argmax_seg.sv
// Streaming arg-max over NUM_CLASSES serial scores, with a registered seven-segment result.
// Define NEURAL_SEG_DP_EN to show non-confident results as the digit with dp lit instead of blank.
module neural_argmax_seg #(
  parameter  int NUM_CLASSES = 10,
  parameter  int DATA_W      = 16,
  localparam int IDX_W       = (NUM_CLASSES <= 1) ? 1 : $clog2(NUM_CLASSES)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [DATA_W-1:0] score_in,
  input  logic              score_valid,
  output logic              score_ready,
  input  logic              frame_clr,
  input  logic [DATA_W-1:0] conf_margin,
  output logic [7:0]        seven_seg,
  output logic [IDX_W-1:0]  class_idx,
  output logic              confident,
  output logic              result_valid
);

  typedef enum logic {ACCUM, DECIDE} state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_beat;
  logic [DATA_W-1:0] r_best;
  logic [DATA_W-1:0] r_second;
  logic [IDX_W-1:0]  r_best_idx;
  logic [7:0]        r_seven_seg;
  logic [IDX_W-1:0]  r_class_idx;
  logic              r_confident;
  logic              r_result_valid;

  logic              w_first;
  logic              w_last;
  logic [DATA_W-1:0] w_diff;
  logic              w_conf;
  logic [7:0]        w_seg;
  logic [7:0]        w_seg_nc;

  function automatic logic [7:0] f_seg(input logic [IDX_W-1:0] idx);
    logic [31:0] w;
    w     = 32'(idx);
    f_seg = 8'h40;
    if (w < 32'd16) begin
      case (w[3:0])
        4'h0: f_seg = 8'h3F;
        4'h1: f_seg = 8'h06;
        4'h2: f_seg = 8'h5B;
        4'h3: f_seg = 8'h4F;
        4'h4: f_seg = 8'h66;
        4'h5: f_seg = 8'h6D;
        4'h6: f_seg = 8'h7D;
        4'h7: f_seg = 8'h07;
        4'h8: f_seg = 8'h7F;
        4'h9: f_seg = 8'h6F;
        4'hA: f_seg = 8'h77;
        4'hB: f_seg = 8'h7C;
        4'hC: f_seg = 8'h39;
        4'hD: f_seg = 8'h5E;
        4'hE: f_seg = 8'h79;
        default: f_seg = 8'h71;
      endcase
    end
  endfunction

  assign score_ready = (r_state == ACCUM) & ~frame_clr;
  assign w_first     = (r_beat == '0);
  assign w_last      = (r_beat == IDX_W'(NUM_CLASSES - 1));
  // best >= second always holds, so the difference cannot wrap
  assign w_diff      = r_best - r_second;
  assign w_conf      = (w_diff >= conf_margin);
  assign w_seg       = f_seg(r_best_idx);
`ifdef NEURAL_SEG_DP_EN
  assign w_seg_nc    = {1'b1, w_seg[6:0]};
`else
  assign w_seg_nc    = 8'h00;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state        <= ACCUM;
      r_beat         <= '0;
      r_best         <= '0;
      r_second       <= '0;
      r_best_idx     <= '0;
      r_seven_seg    <= 8'h00;
      r_class_idx    <= '0;
      r_confident    <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      case (r_state)
        ACCUM: begin
          if (frame_clr) begin
            r_beat     <= '0;
            r_best     <= '0;
            r_second   <= '0;
            r_best_idx <= '0;
          end else if (score_valid) begin
            if (w_first) begin
              r_best     <= score_in;
              r_best_idx <= '0;
              r_second   <= '0;
            end else if (score_in > r_best) begin
              r_second   <= r_best;
              r_best     <= score_in;
              r_best_idx <= r_beat;
            end else if (score_in > r_second) begin
              r_second   <= score_in;
            end
            if (w_last) r_state <= DECIDE;
            else        r_beat  <= r_beat + 1'b1;
          end
        end
        DECIDE: begin
          r_class_idx    <= r_best_idx;
          r_confident    <= w_conf;
          r_seven_seg    <= w_conf ? w_seg : w_seg_nc;
          r_result_valid <= 1'b1;
          r_beat         <= '0;
          r_state        <= ACCUM;
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign seven_seg    = r_seven_seg;
  assign class_idx    = r_class_idx;
  assign confident    = r_confident;
  assign result_valid = r_result_valid;

endmodule

// File: tb/tb_neural_argmax_seg.sv
// Randomized bench for neural_argmax_seg against a frame-level arg-max model, plus literal pins.
module tb_neural_argmax_seg;
  localparam int NC = 10;
  localparam int DW = 16;
  typedef logic [DW-1:0] frame_t [NC];

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic [DW-1:0] score_in = '0;
  logic          score_valid = 1'b0;
  logic          score_ready;
  logic          frame_clr = 1'b0;
  logic [DW-1:0] conf_margin = 16'd64;
  logic [7:0]    seven_seg;
  logic [3:0]    class_idx;
  logic          confident;
  logic          result_valid;

  neural_argmax_seg #(.NUM_CLASSES(NC), .DATA_W(DW)) dut (
    .clk(clk), .n_rst(n_rst), .score_in(score_in), .score_valid(score_valid),
    .score_ready(score_ready), .frame_clr(frame_clr), .conf_margin(conf_margin),
    .seven_seg(seven_seg), .class_idx(class_idx), .confident(confident),
    .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int rv_cnt = 0;

  logic [7:0] segtab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                              8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_pat(input int idx, input bit conf);
    if (conf) return segtab[idx];
`ifdef NEURAL_SEG_DP_EN
    return segtab[idx] | 8'h80;
`else
    return 8'h00;
`endif
  endfunction

  // Frame-level model: collect accepted scores, then judge the whole frame at once.
  logic [DW-1:0] q [$];
  bit            m_dec;
  logic [7:0]    e_seg;
  logic [3:0]    e_idx;
  bit            e_conf, e_rv;
  int            m_w;
  logic [DW-1:0] m_b, m_s;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      q.delete();
      m_dec  <= 1'b0;
      e_seg  <= 8'h00;
      e_idx  <= 4'd0;
      e_conf <= 1'b0;
      e_rv   <= 1'b0;
    end else begin
      e_rv <= 1'b0;
      if (m_dec) begin
        m_w = 0;
        m_b = q[0];
        for (int i = 1; i < NC; i++) if (q[i] > m_b) begin m_b = q[i]; m_w = i; end
        m_s = '0;
        for (int i = 0; i < NC; i++) if (i != m_w && q[i] > m_s) m_s = q[i];
        e_idx  <= 4'(m_w);
        e_conf <= ((m_b - m_s) >= conf_margin);
        e_seg  <= exp_pat(m_w, ((m_b - m_s) >= conf_margin));
        e_rv   <= 1'b1;
        m_dec  <= 1'b0;
        q.delete();
      end else if (frame_clr) begin
        q.delete();
      end else if (score_valid) begin
        q.push_back(score_in);
        if (q.size() == NC) m_dec <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (n_rst) begin
      cmp("ready", {31'd0, score_ready}, {31'd0, (!m_dec && !frame_clr)});
      cmp("result_valid", {31'd0, result_valid}, {31'd0, e_rv});
      cmp("seven_seg", {24'd0, seven_seg}, {24'd0, e_seg});
      cmp("class_idx", {28'd0, class_idx}, {28'd0, e_idx});
      cmp("confident", {31'd0, confident}, {31'd0, e_conf});
      if (result_valid) rv_cnt++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic beat(input logic [DW-1:0] v);
    bit acc;
    int n;
    n = 0;
    score_in = v;
    score_valid = 1'b1;
    forever begin
      @(negedge clk);
      acc = score_ready;
      @(posedge clk); #1;
      if (acc) break;
      n++;
      if (n > 40) begin
        cmp("beat_accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    score_valid = 1'b0;
  endtask

  task automatic send_frame(input frame_t f, input int gapmax);
    for (int i = 0; i < NC; i++) begin
      beat(f[i]);
      if (gapmax > 0) idle($urandom_range(0, gapmax));
    end
  endtask

  task automatic clr_pulse();
    frame_clr   = 1'b1;
    score_valid = 1'($urandom_range(0, 1));
    score_in    = 16'($urandom_range(0, 16'hFFFF));
    @(posedge clk); #1;
    frame_clr   = 1'b0;
    score_valid = 1'b0;
  endtask

  task automatic pin(input string nm, input logic [7:0] s, input logic [3:0] i, input bit c);
    cmp({nm, "_seg"}, {24'd0, seven_seg}, {24'd0, s});
    cmp({nm, "_idx"}, {28'd0, class_idx}, {28'd0, i});
    cmp({nm, "_conf"}, {31'd0, confident}, {31'd0, c});
  endtask

  frame_t f2 = '{16'h07F2, 16'h01BB, 16'h00BF, 16'h01D7, 16'h0065,
                 16'h0208, 16'h001A, 16'h0037, 16'h001F, 16'h0017};
  frame_t f3 = '{16'h00C5, 16'h002F, 16'h0104, 16'h0018, 16'h0F26,
                 16'h0012, 16'h0026, 16'h005C, 16'h002A, 16'h00E9};
  frame_t f4 = '{16'h01F2, 16'h01BB, 16'h00BF, 16'h01D7, 16'h0065,
                 16'h0208, 16'h001A, 16'h0037, 16'h001F, 16'h0017};
  frame_t f5 = '{default: 16'h0100};

  initial begin
    #5000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t fr;
    int     c0;
    #3;
    pin("reset", 8'h00, 4'd0, 1'b0);
    cmp("reset_rv", {31'd0, result_valid}, 32'd0);
    cmp("reset_ready", {31'd0, score_ready}, 32'd1);
    #14 n_rst = 1'b1;
    idle(2);

    c0 = rv_cnt;
    send_frame(f2, 0);
    idle(3);
    pin("t2", 8'h3F, 4'd0, 1'b1);
    cmp("t2_pulses", 32'(rv_cnt - c0), 32'd1);

    send_frame(f3, 0);
    idle(3);
    pin("t3", 8'h66, 4'd4, 1'b1);

`ifdef NEURAL_SEG_DP_EN
    send_frame(f4, 1); idle(3); pin("t4", 8'hED, 4'd5, 1'b0);
`else
    send_frame(f4, 1); idle(3); pin("t4", 8'h00, 4'd5, 1'b0);
`endif

    conf_margin = 16'd0;
    send_frame(f5, 0);
    idle(3);
    pin("t5", 8'h3F, 4'd0, 1'b1);

    conf_margin = 16'd64;
    c0 = rv_cnt;
    for (int i = 0; i < 5; i++) beat(16'($urandom_range(0, 16'hFFFF)));
    clr_pulse();
    send_frame(f3, 3);
    idle(4);
    cmp("t6_pulses", 32'(rv_cnt - c0), 32'd1);
    pin("t6", 8'h66, 4'd4, 1'b1);

    // asynchronous reset in the middle of a frame
    for (int i = 0; i < 3; i++) beat(16'h0F00);
    #2 n_rst = 1'b0;
    #1;
    pin("arst", 8'h00, 4'd0, 1'b0);
    cmp("arst_ready", {31'd0, score_ready}, 32'd1);
    #9 n_rst = 1'b1;
    idle(2);

    for (int k = 0; k < 60; k++) begin
      conf_margin = 16'($urandom_range(0, 400));
      for (int i = 0; i < NC; i++)
        fr[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3))
                                            : 16'($urandom_range(0, 700));
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < int'($urandom_range(0, NC - 1)); i++) beat(fr[i]);
        clr_pulse();
      end
      send_frame(fr, (k % 3 == 0) ? 0 : 2);
      conf_margin = 16'($urandom_range(0, 400));
      if (k % 4 == 0) idle($urandom_range(0, 3));
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
